// File: rtl/odd_issue.sv
// Odd-pipe issue stage: holds one decoded instruction, tracks in-flight producers
// in a 7-deep age shift register, and issues when no RAW hazard remains.
module odd_issue (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [0:10] in_op,
   input  logic [2:0]  in_format,
   input  logic [1:0]  in_unit,
   input  logic [0:17] in_imm,
   input  logic [0:6]  in_rt_addr,
   input  logic [0:6]  in_ra_addr,
   input  logic [0:6]  in_rb_addr,
   input  logic        in_reg_write,
   input  logic        in_uses_ra,
   input  logic        in_uses_rb,
   output logic [0:10] op,
   output logic [2:0]  format,
   output logic [1:0]  unit,
   output logic [0:17] imm,
   output logic [0:6]  rt_addr,
   output logic        reg_write,
   output logic        issue,
   output logic [2:0]  ra_sel,
   output logic [2:0]  rb_sel,
   output logic [15:0] stall_cycles
);

   typedef struct packed {
      logic       valid;
      logic [0:6] rt_addr;
      logic       reg_write;
      logic [2:0] lat;
   } slot_t;

   slot_t      slot [1:7];
   logic       hold_valid;
   logic [0:6] hold_ra_addr;
   logic [0:6] hold_rb_addr;
   logic       hold_uses_ra;
   logic       hold_uses_rb;

   logic [5:0] ra_prod;
   logic [5:0] rb_prod;
   logic [2:0] ra_k;
   logic [2:0] rb_k;
   logic       hazard_ra;
   logic       hazard_rb;

   function automatic logic [2:0] unit_latency(input logic [1:0] u);
      case (u)
         2'd1:    return 3'd6;
         2'd2:    return 3'd1;
         default: return 3'd4;
      endcase
   endfunction

   // Returns {k, latency} of the youngest matching producer, or zero when none.
   function automatic logic [5:0] find_producer(input logic [0:6] s, input logic uses,
                                                input slot_t sl [1:7]);
      logic [5:0] r;
      logic       found;
      r = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= 7; k++) begin
         if (!found && uses && sl[k].valid && sl[k].reg_write && sl[k].rt_addr == s) begin
            r = {3'(k), sl[k].lat};
            found = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      ra_prod   = find_producer(hold_ra_addr, hold_uses_ra, slot);
      rb_prod   = find_producer(hold_rb_addr, hold_uses_rb, slot);
      ra_k      = ra_prod[5:3];
      rb_k      = rb_prod[5:3];
      hazard_ra = hold_valid && (ra_k != '0) && (ra_k < ra_prod[2:0]);
      hazard_rb = hold_valid && (rb_k != '0) && (rb_k < rb_prod[2:0]);
      issue     = hold_valid && !hazard_ra && !hazard_rb && !flush;
      in_ready  = (!hold_valid || issue) && !flush;
      ra_sel    = (hold_valid && !hazard_ra) ? ra_k : '0;
      rb_sel    = (hold_valid && !hazard_rb) ? rb_k : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid   <= 1'b0;
         stall_cycles <= '0;
         for (int unsigned k = 1; k <= 7; k++) slot[k] <= '0;
      end else begin
         if (flush) begin
            hold_valid <= 1'b0;
         end else if (in_valid && in_ready) begin
            hold_valid   <= 1'b1;
            op           <= in_op;
            format       <= in_format;
            unit         <= in_unit;
            imm          <= in_imm;
            rt_addr      <= in_rt_addr;
            reg_write    <= in_reg_write;
            hold_ra_addr <= in_ra_addr;
            hold_rb_addr <= in_rb_addr;
            hold_uses_ra <= in_uses_ra;
            hold_uses_rb <= in_uses_rb;
         end else if (issue) begin
            hold_valid <= 1'b0;
         end

         if (hold_valid && !issue && !flush && stall_cycles != '1)
            stall_cycles <= stall_cycles + 16'd1;

         slot[1] <= issue ? {1'b1, rt_addr, reg_write, unit_latency(unit)} : '0;
         for (int unsigned k = 2; k <= 7; k++) slot[k] <= slot[k-1];
      end
   end

endmodule

// File: tb/tb_odd_issue.sv
// Bench for odd_issue: directed hazard scenarios plus random traffic, all compared
// against a timestamp-based issue-history model.
module tb_odd_issue;

   logic        clk, reset, flush, in_valid, in_ready;
   logic [0:10] in_op;
   logic [2:0]  in_format;
   logic [1:0]  in_unit;
   logic [0:17] in_imm;
   logic [0:6]  in_rt_addr, in_ra_addr, in_rb_addr;
   logic        in_reg_write, in_uses_ra, in_uses_rb;
   logic [0:10] op;
   logic [2:0]  format;
   logic [1:0]  unit;
   logic [0:17] imm;
   logic [0:6]  rt_addr;
   logic        reg_write, issue;
   logic [2:0]  ra_sel, rb_sel;
   logic [15:0] stall_cycles;

   odd_issue dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_format(in_format), .in_unit(in_unit), .in_imm(in_imm),
      .in_rt_addr(in_rt_addr), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
      .in_reg_write(in_reg_write), .in_uses_ra(in_uses_ra), .in_uses_rb(in_uses_rb),
      .op(op), .format(format), .unit(unit), .imm(imm), .rt_addr(rt_addr),
      .reg_write(reg_write), .issue(issue), .ra_sel(ra_sel), .rb_sel(rb_sel),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   typedef struct {
      int         cyc;
      logic [0:6] rt;
      bit         rw;
      int         lat;
   } rec_t;

   rec_t        hist [$];
   int          now = 0;
   bit          m_hv = 0;
   logic [0:10] m_op;
   logic [1:0]  m_unit;
   logic [0:6]  m_rt, m_ra, m_rb;
   bit          m_rw, m_ura, m_urb;
   int          m_stall = 0;

   logic        s_issue, s_ready;
   logic [2:0]  s_ra, s_rb;
   logic [15:0] s_stall;

   function automatic int lat_of(input logic [1:0] u);
      return (u == 2'd1) ? 6 : (u == 2'd2) ? 1 : 4;
   endfunction

   // Youngest issued writer of s within the last 7 cycles: returns its age, 0 if none.
   task automatic lookup(input logic [0:6] s, input bit uses, output int age, output int lat);
      age = 0;
      lat = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (age == 0 && uses && hist[i].rw && hist[i].rt == s &&
             now - hist[i].cyc >= 1 && now - hist[i].cyc <= 7) begin
            age = now - hist[i].cyc;
            lat = hist[i].lat;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick(input bit do_chk);
      int  ra_age, ra_lat, rb_age, rb_lat;
      bit  hra, hrb, e_issue, e_ready;
      logic [2:0] e_ra, e_rb;
      @(negedge clk);
      s_issue = issue; s_ready = in_ready; s_ra = ra_sel; s_rb = rb_sel; s_stall = stall_cycles;
      lookup(m_ra, m_ura, ra_age, ra_lat);
      lookup(m_rb, m_urb, rb_age, rb_lat);
      hra = m_hv && ra_age != 0 && ra_age < ra_lat;
      hrb = m_hv && rb_age != 0 && rb_age < rb_lat;
      e_issue = m_hv && !hra && !hrb && !flush;
      e_ready = (!m_hv || e_issue) && !flush;
      e_ra = (m_hv && !hra) ? 3'(ra_age) : 3'd0;
      e_rb = (m_hv && !hrb) ? 3'(rb_age) : 3'd0;
      if (do_chk) begin
         check("issue", 32'(issue), 32'(e_issue));
         check("in_ready", 32'(in_ready), 32'(e_ready));
         check("ra_sel", 32'(ra_sel), 32'(e_ra));
         check("rb_sel", 32'(rb_sel), 32'(e_rb));
         check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
         if (m_hv) begin
            check("op", 32'(op), 32'(m_op));
            check("rt_addr", 32'(rt_addr), 32'(m_rt));
         end
      end
      if (reset) begin
         m_hv = 0;
         m_stall = 0;
         hist.delete();
      end else begin
         if (e_issue) hist.push_back('{now, m_rt, m_rw, lat_of(m_unit)});
         if (m_hv && !e_issue && !flush && m_stall < 65535) m_stall++;
         if (flush) m_hv = 0;
         else if (in_valid && e_ready) begin
            m_hv = 1; m_op = in_op; m_unit = in_unit; m_rt = in_rt_addr;
            m_ra = in_ra_addr; m_rb = in_rb_addr; m_rw = in_reg_write;
            m_ura = in_uses_ra; m_urb = in_uses_rb;
         end else if (e_issue) m_hv = 0;
      end
      now++;
      while (hist.size() > 0 && now - hist[0].cyc > 7) void'(hist.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] u, input int rt, input int ra, input int rb,
                        input bit rw, input bit ura, input bit urb);
      in_valid = 1'b1; in_unit = u; in_op = 11'($urandom); in_imm = 18'($urandom);
      in_format = 3'($urandom); in_rt_addr = 7'(rt); in_ra_addr = 7'(ra); in_rb_addr = 7'(rb);
      in_reg_write = rw; in_uses_ra = ura; in_uses_rb = urb;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; flush = 1'b0; reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      offer(0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      tick(1);
      check("reset_issue", 32'(s_issue), 0);
      check("reset_ready", 32'(s_ready), 1);
      check("reset_stall", 32'(s_stall), 0);

      // Perm producer of r5, dependent reader stalls three cycles
      do_reset();
      offer(0, 5, 0, 0, 1, 0, 0); tick(1);
      offer(0, 1, 5, 0, 0, 1, 0); tick(1);
      check("perm_issue_t", 32'(s_issue), 1);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("perm_stall_issue", 32'(s_issue), 0);
      end
      tick(1);
      check("perm_dep_issue", 32'(s_issue), 1);
      check("perm_dep_ra_sel", 32'(s_ra), 4);
      check("perm_dep_stall", 32'(s_stall), 3);

      // Youngest producer wins
      do_reset();
      offer(1, 9, 0, 0, 1, 0, 0); tick(1);
      offer(2, 9, 0, 0, 1, 0, 0); tick(1);
      offer(3, 2, 0, 9, 0, 0, 1); tick(1);
      in_valid = 1'b0;
      tick(1);
      check("youngest_issue", 32'(s_issue), 1);
      check("youngest_rb_sel", 32'(s_rb), 1);

      // Producer aged out of the slot window
      do_reset();
      offer(0, 3, 0, 0, 1, 0, 0); tick(1);
      in_valid = 1'b0; tick(1);
      repeat (6) tick(1);
      offer(0, 4, 3, 0, 1, 1, 0); tick(1);
      in_valid = 1'b0; tick(1);
      check("aged_issue", 32'(s_issue), 1);
      check("aged_ra_sel", 32'(s_ra), 0);
      check("aged_stall", 32'(s_stall), 0);

      // Flush of a stalled instruction
      do_reset();
      offer(1, 7, 0, 0, 1, 0, 0); tick(1);
      offer(0, 1, 7, 0, 0, 1, 0); tick(1);
      in_valid = 1'b0; tick(1);
      flush = 1'b1; tick(1);
      check("flush_issue", 32'(s_issue), 0);
      check("flush_ready", 32'(s_ready), 0);
      check("flush_stall", 32'(s_stall), 1);
      flush = 1'b0; tick(1);
      check("post_flush_ready", 32'(s_ready), 1);
      check("post_flush_issue", 32'(s_issue), 0);
      check("post_flush_stall", 32'(s_stall), 1);

      // Reset during a stall clears the hold and all tracking
      do_reset();
      offer(1, 7, 0, 0, 1, 0, 0); tick(1);
      offer(0, 1, 7, 0, 0, 1, 0); tick(1);
      in_valid = 1'b0; tick(1);
      reset = 1'b1; tick(1);
      reset = 1'b0; tick(1);
      check("rst_stall_issue", 32'(s_issue), 0);
      check("rst_stall_ready", 32'(s_ready), 1);
      check("rst_stall_ra_sel", 32'(s_ra), 0);
      check("rst_stall_cnt", 32'(s_stall), 0);
      offer(0, 1, 7, 0, 0, 1, 0); tick(1);
      in_valid = 1'b0; tick(1);
      check("rst_slots_issue", 32'(s_issue), 1);
      check("rst_slots_ra_sel", 32'(s_ra), 0);

      // Random traffic over a small register set to provoke hazards
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         offer(2'($urandom), $urandom_range(3), $urandom_range(3), $urandom_range(3),
               1'($urandom), 1'($urandom), 1'($urandom));
         in_valid = ($urandom_range(3) != 0);
         flush = ($urandom_range(15) == 0);
         reset = ($urandom_range(99) == 0);
         tick(1);
      end
      reset = 1'b0; flush = 1'b0;

      // Self-dependent LS chain: five stall cycles per six, long enough to saturate
      do_reset();
      offer(1, 5, 5, 0, 1, 1, 0);
      for (int i = 0; i < 80000; i++) tick(0);
      in_valid = 1'b0;
      tick(1);
      check("stall_saturated", 32'(s_stall), 32'hFFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/odd_issue.md
ODD_ISSUE -- requirements
Module: odd_issue

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: flush  in  1  discards the held (not yet issued) instruction.
REQ-004 SHALL have ports: in_valid  in  1  decode offers an instruction.
REQ-005 SHALL have ports: in_ready  out  1  block accepts the offered instruction this cycle.
REQ-006 SHALL have ports: in_op [0:10], in_format [2:0], in_unit [1:0], in_imm [0:17]  in  decoded fields.
REQ-007 SHALL have ports: in_rt_addr, in_ra_addr, in_rb_addr [0:6]  in  register addresses.
REQ-008 SHALL have ports: in_reg_write, in_uses_ra, in_uses_rb  in  1 each  writes rt; reads ra; reads rb.
REQ-009 SHALL have ports: op, format, unit, imm, rt_addr, reg_write  out  held fields to the odd pipe.
REQ-010 SHALL have ports: issue  out  1  odd pipe consumes the fields this cycle.
REQ-011 SHALL have ports: ra_sel, rb_sel [2:0]  out  0 = register file, k = 1..7 = forward from stage k (7 = rt_wb).
REQ-012 SHALL have ports: stall_cycles [15:0]  out  saturating hazard-stall counter.

Function
REQ-013 SHALL hold one instruction in a hold register (hold_valid plus all in_* fields).
REQ-014 SHALL assert in_ready = !hold_valid | issue; on in_valid & in_ready the hold register loads at the clock edge.
REQ-015 SHALL drive op/format/unit/imm/rt_addr/reg_write combinationally from the hold register.
REQ-016 SHALL assign unit latency L: unit 0 (Perm) = 4, 1 (LS) = 6, 2 (Branch) = 1, 3 = 4.
REQ-017 SHALL keep a 7-entry age shift register slot[1..7] of (valid, rt_addr, reg_write, L); slot[1] at each edge = the instruction issued that cycle, or invalid if none; slot[k+1] <= slot[k]; slot[7] is dropped.
REQ-018 SHALL define producer match for source s: slot[k].valid & slot[k].reg_write & slot[k].rt_addr == s & uses_s.
REQ-019 SHALL select, per source, only the smallest matching k (youngest producer).
REQ-020 SHALL raise a RAW hazard for a source when its selected producer has k < L.
REQ-021 SHALL otherwise drive sel = k for the selected producer, or 0 when no producer matches.
REQ-022 SHALL assert issue = hold_valid & !hazard_ra & !hazard_rb & !flush.
REQ-023 SHALL clear hold_valid at the edge when issue is asserted and no new load occurs.
REQ-024 SHALL on flush clear hold_valid and block that cycle's load (in_ready = 0 while flush); slot[] is unaffected.
REQ-025 SHALL increment stall_cycles when hold_valid & !issue & !flush, saturating at 16'hFFFF.
REQ-026 SHALL drive ra_sel/rb_sel = 0 when hold_valid = 0.
REQ-027 SHALL never raise a hazard for a source whose uses_* bit is 0, nor against a producer with reg_write = 0.
REQ-028 SHALL support back-to-back issue at one instruction per cycle when no hazard exists.

Reset
REQ-029 SHALL on reset clear hold_valid, all slot valid bits and stall_cycles; reset takes priority over flush and load.
REQ-030 SHALL drive outputs after reset as: issue = 0, in_ready = 1, ra_sel = rb_sel = 0, stall_cycles = 0.
REQ-031 SHALL allow reset mid-stall to discard the held instruction and all in-flight tracking.

Verification
REQ-032 SHALL pass this scenario: Perm writing r5 issued at t, dependent reading ra = r5 held from t+1 -> issue low t+1..t+3, high at t+4 with ra_sel = 4, stall_cycles = 3.
REQ-033 SHALL pass this scenario: LS writing r9 at t, Branch writing r9 at t+1, reader of rb = r9 at t+2 -> youngest (Branch, k = 1) wins, issue at t+2, rb_sel = 1.
REQ-034 SHALL pass this scenario: reader of r3 issued 8 cycles after producer of r3 -> ra_sel = 0, no stall.
REQ-035 SHALL pass this scenario: stalled instruction, flush pulsed -> issue = 0, next cycle hold_valid = 0 and in_ready = 1, counter unchanged by flush cycle.
REQ-036 SHALL pass this scenario: 70000 consecutive stall cycles -> stall_cycles = 16'hFFFF.
REQ-037 SHALL pass this scenario: reset asserted during a stall with valid slots -> next cycle issue = 0, all slots invalid, in_ready = 1.
